// File: rtl/dircc_rts_pkg.sv
// Shared types and helpers for the DIRCC ready-to-send scheduler.
package dircc_rts_pkg;

  localparam int unsigned FLAG_W = 32;

  typedef enum logic [0:0] {
    RTS_IDLE,
    RTS_OFFER
  } rts_state_t;

  // Port p maps to OUTPUT_FLAG bit p.
  function automatic logic [FLAG_W-1:0] port_to_flag(input int unsigned port);
    logic [FLAG_W-1:0] flag;
    flag = '0;
    flag[port[4:0]] = 1'b1;
    return flag;
  endfunction

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module dircc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               grant_valid
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/dircc_rts_scheduler.sv
// Tracks per-device ready-to-send bits and offers one (device, port) send at a time,
// round-robin across devices, lowest port first within a device.
module dircc_rts_scheduler
  import dircc_rts_pkg::*;
#(
  parameter int unsigned NUM_DEVICES = 4,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned COUNT_WIDTH = 16,
  localparam int unsigned DEV_W      = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1,
  localparam int unsigned PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [COUNT_WIDTH-1:0] max_time,
  input  logic                   upd_valid,
  input  logic [DEV_W-1:0]       upd_dev,
  input  logic [NUM_PORTS-1:0]   upd_rts,
  input  logic [COUNT_WIDTH-1:0] upd_count,
  input  logic                   upd_running,
  output logic                   send_valid,
  input  logic                   send_ready,
  output logic [DEV_W-1:0]       send_dev,
  output logic [FLAG_W-1:0]      send_flag,
  output logic [NUM_DEVICES-1:0] pending_mask
);

  rts_state_t state_q;
  logic [DEV_W-1:0] rr_ptr_q;
  logic [NUM_DEVICES-1:0][NUM_PORTS-1:0] pend_q, pend_d;

  logic                 accept;
  logic [NUM_PORTS-1:0] upd_row;
  logic [NUM_PORTS-1:0] accept_clr;
  logic [NUM_PORTS-1:0] grant_row;
  logic [DEV_W-1:0]     grant;
  logic                 grant_valid;
  logic [PORT_W-1:0]    pick_port;

  assign accept     = send_valid && send_ready;
  assign upd_row    = (upd_running && (upd_count < max_time)) ? upd_rts : '0;
  assign accept_clr = send_flag[NUM_PORTS-1:0];

  // Update lands first; a same-cycle accept on that device still clears its bit.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
      if (upd_valid && (32'(upd_dev) == d)) pend_d[d] = upd_row;
      if (accept && (32'(send_dev) == d)) pend_d[d] = pend_d[d] & ~accept_clr;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned d = 0; d < NUM_DEVICES; d++) pending_mask[d] = |pend_q[d];
  end

  dircc_rr_arbiter #(
    .NUM_REQ (NUM_DEVICES),
    .IDX_W   (DEV_W)
  ) u_arb (
    .req         (pending_mask),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    logic found;
    found     = 1'b0;
    grant_row = '0;
    pick_port = '0;
    for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
      if (32'(grant) == d) grant_row = pend_q[d];
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!found && grant_row[p]) begin
        found     = 1'b1;
        pick_port = PORT_W'(p);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      rr_ptr_q   <= '0;
      state_q    <= RTS_IDLE;
      send_valid <= 1'b0;
      send_dev   <= '0;
      send_flag  <= '0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        RTS_IDLE: begin
          if (grant_valid) begin
            send_dev  <= grant;
            send_flag <= port_to_flag(32'(pick_port));
            state_q   <= RTS_OFFER;
          end
        end
        RTS_OFFER: begin
          if (accept) begin
            send_valid <= 1'b0;
            rr_ptr_q   <= (32'(send_dev) == NUM_DEVICES - 1) ? '0 : send_dev + DEV_W'(1);
            state_q    <= RTS_IDLE;
          end else begin
            send_valid <= 1'b1;
          end
        end
        default: state_q <= RTS_IDLE;
      endcase
    end
  end

endmodule
